// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D conversion sequencer: channel numbers, FSM states, command format, slot order.
// Build option A2D_TORQUE_PRIO_EN selects the 6-slot torque-priority order instead of the 4-slot round robin.
package a2d_pkg;

    localparam logic [2:0] CH_BATT   = 3'd0;
    localparam logic [2:0] CH_CURR   = 3'd1;
    localparam logic [2:0] CH_TORQUE = 3'd4;
    localparam logic [2:0] CH_INCL   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT,
        ST_LATCH
    } state_t;

`ifdef A2D_TORQUE_PRIO_EN
    localparam int NUM_SLOTS = 6;
    localparam int SLOT_W    = 3;
`else
    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;
`endif

    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    function automatic logic [2:0] slot_ch_rr(input logic [1:0] idx);
        case (idx)
            2'd0:    return CH_BATT;
            2'd1:    return CH_CURR;
            2'd2:    return CH_TORQUE;
            default: return CH_INCL;
        endcase
    endfunction

    // Torque on every even slot so it is refreshed every second conversion.
    function automatic logic [2:0] slot_ch_prio(input logic [2:0] idx);
        case (idx)
            3'd0:    return CH_TORQUE;
            3'd1:    return CH_BATT;
            3'd2:    return CH_TORQUE;
            3'd3:    return CH_CURR;
            3'd4:    return CH_TORQUE;
            default: return CH_INCL;
        endcase
    endfunction

    function automatic logic [2:0] slot_ch(input logic [SLOT_W-1:0] idx);
`ifdef A2D_TORQUE_PRIO_EN
        return slot_ch_prio(idx);
`else
        return slot_ch_rr(idx);
`endif
    endfunction

endpackage

// File: rtl/a2d_slot_seq.sv
// Slot counter for the conversion sequence; maps the current slot to its A2D channel number.
// Slot count and order follow A2D_TORQUE_PRIO_EN through a2d_pkg.
module a2d_slot_seq
    import a2d_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [SLOT_W-1:0] ch_idx,
    output logic [2:0]        ch
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx <= '0;
        end else if (advance) begin
            ch_idx <= (ch_idx == LAST_SLOT) ? '0 : ch_idx + 1'b1;
        end
    end

    assign ch = slot_ch(ch_idx);

endmodule

// File: rtl/a2d_round_robin_sched.sv
// Sequences one SPI A2D read per interval and latches each 12-bit result into its channel register.
// Build option A2D_TORQUE_PRIO_EN selects the torque-priority slot order (see a2d_pkg).
module a2d_round_robin_sched
    import a2d_pkg::*;
#(
    parameter bit FAST_SIM = 1'b0,
    parameter int TMO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    output logic              strt,
    output logic [15:0]       cmd,
    input  logic              done,
    input  logic [15:0]       rd_data,
    output logic [11:0]       batt,
    output logic [11:0]       curr,
    output logic [11:0]       torque,
    output logic [11:0]       incline,
    output logic              batt_vld,
    output logic              curr_vld,
    output logic              torque_vld,
    output logic              incline_vld,
    output logic              tmo_err,
    output logic [SLOT_W-1:0] ch_idx
);

    localparam int IVL_W = FAST_SIM ? 7 : 14;

    state_t           state;
    logic [IVL_W-1:0] ivl_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       ch;
    logic             ivl_tc;
    logic             tmo_tc;
    logic             advance;
    logic             unused_rd_hi;

    assign ivl_tc       = &ivl_cnt;
    assign tmo_tc       = &tmo_cnt;
    assign unused_rd_hi = ^rd_data[15:12];

    // A done arriving on the timeout terminal count takes the LATCH path, so no slot skip here.
    assign advance = (state == ST_LATCH) || ((state == ST_WAIT) && !done && tmo_tc);

    a2d_slot_seq u_slot_seq (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .ch_idx  (ch_idx),
        .ch      (ch)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ivl_cnt     <= '0;
            tmo_cnt     <= '0;
            strt        <= 1'b0;
            cmd         <= 16'h0000;
            batt        <= 12'h000;
            curr        <= 12'h000;
            torque      <= 12'h000;
            incline     <= 12'h000;
            batt_vld    <= 1'b0;
            curr_vld    <= 1'b0;
            torque_vld  <= 1'b0;
            incline_vld <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            strt        <= 1'b0;
            batt_vld    <= 1'b0;
            curr_vld    <= 1'b0;
            torque_vld  <= 1'b0;
            incline_vld <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ivl_tc) begin
                        ivl_cnt <= '0;
                        strt    <= 1'b1;
                        cmd     <= build_cmd(ch);
                        state   <= ST_CMD;
                    end else begin
                        ivl_cnt <= ivl_cnt + 1'b1;
                    end
                end
                ST_CMD: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Result registers load on the done edge so they are visible in the LATCH cycle.
                    if (done) begin
                        case (ch)
                            CH_BATT:   begin batt    <= rd_data[11:0]; batt_vld    <= 1'b1; end
                            CH_CURR:   begin curr    <= rd_data[11:0]; curr_vld    <= 1'b1; end
                            CH_TORQUE: begin torque  <= rd_data[11:0]; torque_vld  <= 1'b1; end
                            CH_INCL:   begin incline <= rd_data[11:0]; incline_vld <= 1'b1; end
                            default:   ;
                        endcase
                        state <= ST_LATCH;
                    end else if (tmo_tc) begin
                        tmo_err <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
